tx_sched: RTL and testbench
===========================

# tx_sched

Transmit scheduler sitting in front of the `tx` serializer. It arbitrates byte requests from two sources with round-robin fairness and loads the granted byte into the serializer. It counts completed transmissions against the programmable `max_tx_count` budget and raises `max_tx_flag` when the budget is exhausted. A done-timeout watchdog covers a stalled serializer.

## Interface
Parameters:
- `DATA_W`, 8: width of a transmit word (matches `reg_data`).
- `CNT_W`, 32: width of `max_tx_count` and `tx_count`.
- `TIMEOUT`, 1024: maximum cycles to wait for `tx_done` after a load.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a word.
- `req0_data`  in  DATA_W  requester 0 word.
- `req0_ready`  out  1  requester 0 word accepted when `valid && ready`.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0, for requester 1.
- `max_tx_count`  in  CNT_W  transmit budget in words; 0 means unlimited.
- `count_clr`  in  1  clears `tx_count`, `max_tx_flag` and `tmo_err`.
- `tx_done`  in  1  one-cycle pulse from the serializer after the last bit.
- `reg_data`  out  DATA_W  word to serializer; held stable from load until the next load.
- `tx_load`  out  1  one-cycle start pulse to the serializer.
- `tx_count`  out  CNT_W  number of completed words.
- `max_tx_flag`  out  1  budget reached; sticky.
- `tmo_err`  out  1  watchdog fired; sticky.
- `grant_id`  out  1  requester of the word currently or last loaded.
- `busy`  out  1  high in LOAD and WAIT.

## Operation
- States: IDLE, LOAD, WAIT, STOP.
- IDLE:
  - Ready is offered only while `max_tx_flag == 0`.
  - Exactly one `reqN_ready` is high (combinational from state, flag and valids): the valid requester.
  - If both are valid, the requester opposite to `grant_id` wins.
  - If neither is valid, no ready is asserted.
  - On handshake: capture data into `reg_data`, set `grant_id`, go to LOAD.
- LOAD: `tx_load = 1` for exactly one cycle, clear the watchdog counter, go to WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On `tx_done`: `tx_count <= tx_count + 1`.
  - If `max_tx_count != 0` and `tx_count + 1 >= max_tx_count`: set `max_tx_flag` and go to STOP; otherwise go to IDLE.
  - If the watchdog reaches `TIMEOUT - 1` without `tx_done`: set `tmo_err`, go to IDLE, and do not increment `tx_count`.
- STOP: all ready low. Exit to IDLE only via `count_clr` or `rst`.
- `count_clr` is accepted in any state:
  - It zeroes `tx_count`, `max_tx_flag` and `tmo_err` next cycle.
  - It does not abort an in-flight word.
  - If it coincides with `tx_done`, clear wins: count becomes 0 and the flag is not set.
- `tx_done` outside WAIT is ignored.
- `max_tx_count` is sampled only at `tx_done`. Lowering it below `tx_count` mid-run causes the flag to set on the next completion (`>=` compare).
- `tx_count` saturates at all-ones; it does not wrap.

## Timing
- Reset values: all outputs 0; state IDLE; `grant_id = 1`, so requester 0 wins the first tie.
- Handshake in cycle N puts `reg_data` valid and `tx_load = 1` in cycle N+1.
- The earliest next handshake is the cycle after the `tx_done` cycle, giving a minimum spacing of 3 cycles plus serializer latency.
- `tx_count` and `max_tx_flag` update in the cycle after `tx_done`.
- Ready is never asserted in LOAD, WAIT or STOP, so back-to-back accepts cannot occur.
- `rst` mid-operation aborts immediately: the next `tx_load` is suppressed and the captured word is dropped.

## Test plan
- Reset then single word: `req0_valid=1`, data `8'h9A` → `req0_ready` high in the first IDLE cycle, `tx_load` pulse the next cycle with `reg_data=8'h9A`; `tx_done` → `tx_count=1`.
- Round-robin: both valid continuously, 4 words → grants 0,1,0,1; `req1_data` appears on the 2nd and 4th loads.
- Budget: `max_tx_count=3`, stream 5 words → after the 3rd `tx_done`, `max_tx_flag=1`, state STOP, readies low; `count_clr` → `tx_count=0`, flag 0, the 4th word is accepted.
- Unlimited: `max_tx_count=0`, 10 words → flag never set, `tx_count=10`.
- Watchdog: `TIMEOUT=16`, withhold `tx_done` → `tmo_err=1` 16 cycles after `tx_load`, `tx_count` unchanged, next request is served.
- Corner cases:
  - `count_clr` coincident with `tx_done` → `tx_count=0`.
  - `rst` asserted during WAIT → all outputs 0 next cycle.
  - Stray `tx_done` in IDLE → no count change.

Source files
------------

// File: rtl/tx_sched.sv
// tx_sched: round-robin arbiter between two byte sources feeding the tx serializer, with a completion budget and done-timeout watchdog.
module tx_sched #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic [CNT_W-1:0]  max_tx_count,
  input  logic              count_clr,
  input  logic              tx_done,
  output logic [DATA_W-1:0] reg_data,
  output logic              tx_load,
  output logic [CNT_W-1:0]  tx_count,
  output logic              max_tx_flag,
  output logic              tmo_err,
  output logic              grant_id,
  output logic              busy
);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, STOP} state_t;
  state_t state, state_n;
  logic [WW-1:0] wdog;
  logic [CNT_W:0] inc;
  logic offer, accept, done, tmo, hit;
  assign offer = state == IDLE && !max_tx_flag;
  assign req0_ready = offer && req0_valid && (!req1_valid || grant_id);
  assign req1_ready = offer && req1_valid && (!req0_valid || !grant_id);
  assign accept = req0_ready || req1_ready;
  assign tx_load = state == LOAD;
  assign busy = state == LOAD || state == WAIT;
  assign done = state == WAIT && tx_done;
  // Fires on the last allowed wait cycle so tmo_err shows TIMEOUT cycles after the load pulse.
  assign tmo = state == WAIT && !tx_done && int'(wdog) == TIMEOUT - 2;
  assign inc = {1'b0, tx_count} + (CNT_W+1)'(1);
  assign hit = |max_tx_count && inc >= {1'b0, max_tx_count};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? LOAD : IDLE;
      LOAD: state_n = WAIT;
      WAIT: state_n = (done && hit && !count_clr) ? STOP : (done || tmo) ? IDLE : WAIT;
      STOP: state_n = count_clr ? IDLE : STOP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      reg_data    <= '0;
      grant_id    <= 1'b1;
      tx_count    <= '0;
      max_tx_flag <= 1'b0;
      tmo_err     <= 1'b0;
      wdog        <= '0;
    end else begin
      if (accept) begin
        reg_data <= req1_ready ? req1_data : req0_data;
        grant_id <= req1_ready;
      end
      wdog <= state == LOAD ? '0 : state == WAIT ? wdog + WW'(1) : wdog;
      if (count_clr) begin
        tx_count    <= '0;
        max_tx_flag <= 1'b0;
        tmo_err     <= 1'b0;
      end else begin
        if (done) tx_count <= inc[CNT_W] ? tx_count : inc[CNT_W-1:0];
        if (done && hit) max_tx_flag <= 1'b1;
        if (tmo) tmo_err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: random stimulus against a transaction-age reference model of tx_sched.
module tb_tx_sched;
  localparam int DW = 8, CW = 8, TMO = 16;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [DW-1:0] req0_data = 0, req1_data = 0, reg_data;
  logic [CW-1:0] max_tx_count = 0, tx_count;
  logic count_clr = 0, tx_done = 0, tx_load, max_tx_flag, tmo_err, grant_id, busy;
  int checks = 0, failures = 0;
  int age = -1, m_cnt = 0;
  bit m_flag = 0, m_tmo = 0, m_gid = 1;
  logic [DW-1:0] m_data = 0;
  int words = 0, timeouts = 0;

  tx_sched #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .max_tx_count(max_tx_count), .count_clr(count_clr), .tx_done(tx_done),
    .reg_data(reg_data), .tx_load(tx_load), .tx_count(tx_count),
    .max_tx_flag(max_tx_flag), .tmo_err(tmo_err), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // age: -1 idle, 0 the load cycle, k>=1 the k-th cycle spent waiting for tx_done
  function automatic bit exp_r0();
    return age < 0 && !m_flag && req0_valid && (!req1_valid || m_gid);
  endfunction
  function automatic bit exp_r1();
    return age < 0 && !m_flag && req1_valid && (!req0_valid || !m_gid);
  endfunction

  task automatic model_step();
    bit a0, a1, dn, to, reach;
    if (rst) begin
      age = -1; m_cnt = 0; m_flag = 0; m_tmo = 0; m_gid = 1; m_data = 0;
      return;
    end
    a0 = exp_r0();
    a1 = exp_r1();
    dn = age >= 1 && tx_done;
    to = age == TMO - 1 && !tx_done;
    reach = max_tx_count != 0 && m_cnt + 1 >= int'(max_tx_count);
    words += int'(dn);
    timeouts += int'(to);
    if (count_clr) begin
      m_cnt = 0; m_flag = 0; m_tmo = 0;
    end else begin
      if (dn) begin
        m_cnt = m_cnt == 255 ? 255 : m_cnt + 1;
        if (reach) m_flag = 1;
      end
      if (to) m_tmo = 1;
    end
    age = (a0 || a1) ? 0 : age == 0 ? 1 : (age >= 1 && !dn && !to) ? age + 1 : -1;
    if (a0 || a1) begin
      m_data = a1 ? req1_data : req0_data;
      m_gid = a1;
    end
  endtask

  task automatic check_all();
    chk("req0_ready", req0_ready, exp_r0());
    chk("req1_ready", req1_ready, exp_r1());
    chk("tx_load", tx_load, age == 0);
    chk("busy", busy, age >= 0);
    chk("reg_data", reg_data, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("tx_count", tx_count, m_cnt);
    chk("max_tx_flag", max_tx_flag, m_flag);
    chk("tmo_err", tmo_err, m_tmo);
  endtask

  task automatic run(input int cycles, input int maxc, input int vp, input int dp,
                     input int cp, input int rpm, input int rst_cycles);
    max_tx_count = CW'(maxc);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      model_step();
      #1;
      rst = c < rst_cycles || $urandom_range(999) < rpm;
      req0_valid = $urandom_range(99) < vp;
      req1_valid = $urandom_range(99) < vp;
      req0_data = DW'($urandom);
      req1_data = DW'($urandom);
      tx_done = $urandom_range(99) < dp;
      count_clr = $urandom_range(99) < cp;
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    run(3, 0, 0, 0, 0, 0, 3);
    chk("reset_tx_count", tx_count, 0);
    chk("reset_grant_id", grant_id, 1);
    for (int s = 0; s < 14; s++) begin
      int dps[4] = '{0, 4, 25, 60};
      int mx = (s % 3 == 0) ? 0 : $urandom_range(1, 6);
      run(300, mx, $urandom_range(30, 100), dps[s % 4], (s % 2) ? 2 : 0, (s % 5 == 4) ? 8 : 0, 2);
    end
    run(2000, 0, 100, 50, 0, 0, 2);
    chk("saturated_count", tx_count, 255);
    chk("saw_timeouts", timeouts > 0, 1);
    chk("saw_words", words > 300, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
